ctrl_ramdrv_tapseq: RTL and testbench
=====================================

// Module: ctrl_ramdrv_tapseq
// PURPOSE
//  Per-output-sample tap sequencer for the polyphase FIR datapath. It sits upstream of the
//  coefficient address counter and drives its load/cnt/coef_ptr inputs. It also generates
//  the sample-RAM read address (newest-to-oldest) and the MAC control strobes.
//  One start request produces one complete dot-product pass over the taps of the selected phase.
// PARAMETERS
//  ADDR_WIDTH      12  coefficient RAM address width (must match the coefficient counter)
//  SMP_ADDR_WIDTH  10  sample ring-buffer address width
//  TAP_WIDTH        8  width of the tap count (max taps per phase = 2^TAP_WIDTH)
//  PHASE_WIDTH      6  polyphase index width
// PORTS
//  clk        in   1               clock; all state updates on posedge
//  rst        in   1               asynchronous, active-high reset
//  start      in   1               request one output sample; accepted only in IDLE
//  phase      in   PHASE_WIDTH     polyphase branch index; sampled with start
//  taps_m1    in   TAP_WIDTH       taps per phase minus 1; sampled with start
//  coef_base  in   ADDR_WIDTH      base address of the coefficient table; sampled with start
//  wr_ptr     in   SMP_ADDR_WIDTH  address of the newest sample; sampled with start
//  busy       out  1               high from CALC through DONE
//  done       out  1               1-cycle pulse in DONE
//  coef_load  out  1               load strobe to the coefficient counter
//  coef_cnt   out  1               count enable to the coefficient counter
//  coef_ptr   out  ADDR_WIDTH      initial coefficient address for the counter
//  smp_addr   out  SMP_ADDR_WIDTH  sample-RAM read address
//  mac_clr    out  1               clear the accumulator; valid on the first tap cycle
//  mac_en     out  1               accumulate enable; valid on every tap cycle
//  mac_last   out  1               final tap cycle; the accumulator result is valid after it
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; coef_ptr=0; smp_addr=0; internal tap counter=0. A reset
//   mid-run aborts immediately with no done pulse. The coefficient counter is resynchronised
//   by the next coef_load.
//  FSM, one state register:
//   IDLE -> CALC on start.
//   CALC -> LOAD.
//   LOAD -> RUN.
//   RUN -> DONE when tap_cnt==0.
//   DONE -> IDLE.
//  IDLE: busy=0. On start, register phase/taps_m1/coef_base/wr_ptr. start in any other
//   state is ignored, not queued.
//  CALC: coef_ptr <= coef_base + phase*(taps_m1+1), truncated mod 2^ADDR_WIDTH.
//   tap_cnt <= taps_m1. smp_addr <= latched wr_ptr.
//  LOAD: coef_load=1 for exactly one cycle; coef_ptr stays stable through LOAD and RUN.
//  RUN: coef_cnt=1 and mac_en=1 every cycle. The downstream counter holds coef_ptr on the
//   first cnt cycle after load and increments on each later cnt cycle. Tap k therefore
//   sees coefficient coef_ptr+k.
//  RUN, per cycle: smp_addr decrements by 1, wrapping mod 2^SMP_ADDR_WIDTH (0 -> all ones).
//   tap_cnt decrements by 1.
//  RUN, strobes: mac_clr=1 on the first RUN cycle only. mac_last=1 when tap_cnt==0.
//   With taps_m1=0, RUN lasts 1 cycle and mac_clr and mac_last are asserted together.
//  DONE: done=1 and busy=1; coef_cnt=0 and mac_en=0.
//  Latency, with start high in cycle 0:
//   CALC in cycle 1; coef_load in cycle 2; RUN in cycles 3..3+taps_m1; done in cycle 4+taps_m1.
//   Earliest next accepted start is cycle 5+taps_m1.
//  Invariants: coef_load and coef_cnt are never high together. mac_* are high only in RUN.
//   All outputs are registered or decoded from the state register only; there is no
//   combinational path from an input to an output.
// STRUCTURE
//  Shared header ctrl_ramdrv_defs.vh: state encodings (IDLE, CALC, LOAD, RUN, DONE, 3-bit)
//   and default widths shared with the coefficient address counter.
//  Sub-module ctrl_ramdrv_tapcnt: a loadable down-counter with a zero flag (TAP_WIDTH),
//   used for tap_cnt.
//  The phase*(taps_m1+1) product is registered in CALC; no combinational multiply feeds
//   an output.
// TESTING
//  1. Reset, then start with phase=0, taps_m1=3, coef_base=0x100, wr_ptr=0x020 ->
//     coef_ptr=0x100; coef_load in cycle 2; 4 RUN cycles; smp_addr 0x020,0x01F,0x01E,0x01D;
//     done in cycle 7.
//  2. phase=5, taps_m1=15, coef_base=0x010 -> coef_ptr=0x060. mac_clr only on the first RUN
//     cycle and mac_last only on the 16th. A bench counter model yields addresses 0x060..0x06F.
//  3. Wrap cases: wr_ptr=0x001, taps_m1=3 -> smp_addr 0x001,0x000,0x3FF,0x3FE.
//     coef_base=0xFF0, phase=1, taps_m1=31 -> coef_ptr=0x010 (mod 2^12).
//  4. taps_m1=0 -> a single RUN cycle with mac_clr=mac_last=mac_en=1; done follows next cycle.
//  5. start held high continuously, and pulsed during RUN and DONE -> those pulses are ignored.
//     Back-to-back passes are separated by IDLE and begin exactly one cycle after start is
//     sampled in IDLE.
//  6. Assert rst during RUN -> all outputs 0 asynchronously and no done pulse. The next start
//     runs a full, correct pass.

Source files
------------

// File: rtl/ctrl_ramdrv_tapseq_pkg.sv
// Shared definitions for the polyphase FIR tap sequencer: FSM state encoding and
// default widths that must agree with the downstream coefficient address counter.
package ctrl_ramdrv_tapseq_pkg;

    localparam int DEF_ADDR_WIDTH     = 12;
    localparam int DEF_SMP_ADDR_WIDTH = 10;
    localparam int DEF_TAP_WIDTH      = 8;
    localparam int DEF_PHASE_WIDTH    = 6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CALC = 3'd1,
        ST_LOAD = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/ctrl_ramdrv_tapcnt.sv
// Loadable down-counter with zero flag; tracks the taps remaining in the current pass.
// Decrement saturates at zero so the count is left clean once a pass finishes.
module ctrl_ramdrv_tapcnt
    import ctrl_ramdrv_tapseq_pkg::*;
#(
    parameter int TAP_WIDTH = DEF_TAP_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic                 i_dec,
    input  logic [TAP_WIDTH-1:0] i_val,
    output logic [TAP_WIDTH-1:0] o_cnt,
    output logic                 o_zero
);

    logic [TAP_WIDTH-1:0] r_cnt;
    logic                 w_zero;

    assign w_zero = (r_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (i_dec && !w_zero) begin
            r_cnt <= r_cnt - TAP_WIDTH'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_zero = w_zero;

endmodule

// File: rtl/ctrl_ramdrv_tapseq.sv
// Per-output-sample tap sequencer: drives the coefficient counter (load/cnt/ptr), the
// sample-RAM read address (newest to oldest) and the MAC strobes for one dot-product pass.
module ctrl_ramdrv_tapseq
    import ctrl_ramdrv_tapseq_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int SMP_ADDR_WIDTH = DEF_SMP_ADDR_WIDTH,
    parameter int TAP_WIDTH      = DEF_TAP_WIDTH,
    parameter int PHASE_WIDTH    = DEF_PHASE_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [PHASE_WIDTH-1:0]    phase,
    input  logic [TAP_WIDTH-1:0]      taps_m1,
    input  logic [ADDR_WIDTH-1:0]     coef_base,
    input  logic [SMP_ADDR_WIDTH-1:0] wr_ptr,
    output logic                      busy,
    output logic                      done,
    output logic                      coef_load,
    output logic                      coef_cnt,
    output logic [ADDR_WIDTH-1:0]     coef_ptr,
    output logic [SMP_ADDR_WIDTH-1:0] smp_addr,
    output logic                      mac_clr,
    output logic                      mac_en,
    output logic                      mac_last
);

    state_t                    r_state;
    logic [PHASE_WIDTH-1:0]    r_phase;
    logic [TAP_WIDTH-1:0]      r_taps_m1;
    logic [ADDR_WIDTH-1:0]     r_coef_base;
    logic [SMP_ADDR_WIDTH-1:0] r_wr_ptr;

    logic [TAP_WIDTH:0]        w_taps;
    logic [ADDR_WIDTH-1:0]     w_phase_off;
    logic [TAP_WIDTH-1:0]      w_tap_cnt;
    logic                      w_tap_zero;
    logic                      w_tap_load;
    logic                      w_tap_dec;

    // Product is only needed modulo 2^ADDR_WIDTH, so both factors are cut to that width
    // first; it feeds the coef_ptr register in CALC and never an output directly.
    assign w_taps      = {1'b0, r_taps_m1} + (TAP_WIDTH + 1)'(1);
    assign w_phase_off = ADDR_WIDTH'(r_phase) * ADDR_WIDTH'(w_taps);

    assign w_tap_load = (r_state == ST_CALC);
    assign w_tap_dec  = (r_state == ST_RUN);

    ctrl_ramdrv_tapcnt #(
        .TAP_WIDTH (TAP_WIDTH)
    ) u_tapcnt (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_tap_load),
        .i_dec  (w_tap_dec),
        .i_val  (r_taps_m1),
        .o_cnt  (w_tap_cnt),
        .o_zero (w_tap_zero)
    );

    // Outputs are set on the transition into the state that owns them, so every strobe
    // is a plain register with no input-to-output path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_phase     <= '0;
            r_taps_m1   <= '0;
            r_coef_base <= '0;
            r_wr_ptr    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            coef_load   <= 1'b0;
            coef_cnt    <= 1'b0;
            coef_ptr    <= '0;
            smp_addr    <= '0;
            mac_clr     <= 1'b0;
            mac_en      <= 1'b0;
            mac_last    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_phase     <= phase;
                        r_taps_m1   <= taps_m1;
                        r_coef_base <= coef_base;
                        r_wr_ptr    <= wr_ptr;
                        busy        <= 1'b1;
                        r_state     <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    coef_ptr  <= r_coef_base + w_phase_off;
                    smp_addr  <= r_wr_ptr;
                    coef_load <= 1'b1;
                    r_state   <= ST_LOAD;
                end
                ST_LOAD: begin
                    coef_load <= 1'b0;
                    coef_cnt  <= 1'b1;
                    mac_en    <= 1'b1;
                    mac_clr   <= 1'b1;
                    mac_last  <= w_tap_zero;
                    r_state   <= ST_RUN;
                end
                ST_RUN: begin
                    smp_addr <= smp_addr - SMP_ADDR_WIDTH'(1);
                    mac_clr  <= 1'b0;
                    if (w_tap_zero) begin
                        coef_cnt <= 1'b0;
                        mac_en   <= 1'b0;
                        mac_last <= 1'b0;
                        done     <= 1'b1;
                        r_state  <= ST_DONE;
                    end else begin
                        // Counter steps to cnt-1 this edge, so the last tap is next when cnt==1.
                        mac_last <= (w_tap_cnt == TAP_WIDTH'(1));
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    coef_load <= 1'b0;
                    coef_cnt  <= 1'b0;
                    mac_clr   <= 1'b0;
                    mac_en    <= 1'b0;
                    mac_last  <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_ramdrv_tapseq.sv
// Bench for ctrl_ramdrv_tapseq: directed table passes, random passes, held/pulsed start,
// and asynchronous reset mid-run, all checked cycle by cycle against timing rules.
module tb_ctrl_ramdrv_tapseq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  phase;
    logic [7:0]  taps_m1;
    logic [11:0] coef_base;
    logic [9:0]  wr_ptr;
    logic        busy, done, coef_load, coef_cnt, mac_clr, mac_en, mac_last;
    logic [11:0] coef_ptr;
    logic [9:0]  smp_addr;

    int checks = 0;
    int errors = 0;

    ctrl_ramdrv_tapseq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .phase     (phase),
        .taps_m1   (taps_m1),
        .coef_base (coef_base),
        .wr_ptr    (wr_ptr),
        .busy      (busy),
        .done      (done),
        .coef_load (coef_load),
        .coef_cnt  (coef_cnt),
        .coef_ptr  (coef_ptr),
        .smp_addr  (smp_addr),
        .mac_clr   (mac_clr),
        .mac_en    (mac_en),
        .mac_last  (mac_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream coefficient counter: address = pointer captured at load + cnt cycles since.
    logic [11:0] m_ptr;
    int          m_n;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ptr <= '0;
            m_n   <= 0;
        end else if (coef_load) begin
            m_ptr <= coef_ptr;
            m_n   <= 0;
        end else if (coef_cnt) begin
            m_n <= m_n + 1;
        end
    end

    typedef struct {
        int phase;
        int taps;
        int base;
        int wr;
        int expc;
        bit hold;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, c, act, exp);
        end
    endtask

    task automatic chk_all_zero(input int c);
        chk("rst_busy", c, 32'(busy), 0);
        chk("rst_done", c, 32'(done), 0);
        chk("rst_load", c, 32'(coef_load), 0);
        chk("rst_cnt", c, 32'(coef_cnt), 0);
        chk("rst_ptr", c, 32'(coef_ptr), 0);
        chk("rst_smp", c, 32'(smp_addr), 0);
        chk("rst_clr", c, 32'(mac_clr), 0);
        chk("rst_en", c, 32'(mac_en), 0);
        chk("rst_last", c, 32'(mac_last), 0);
    endtask

    // Expected outputs in cycle c of a pass whose start was sampled at the end of cycle 0.
    task automatic check_cycle(input int c, input int t, input int wr, input int expc);
        bit run;
        int k;
        run = (c >= 3) && (c <= 3 + t);
        k   = c - 3;
        chk("busy", c, 32'(busy), 32'((c >= 1) && (c <= 4 + t)));
        chk("done", c, 32'(done), 32'(c == 4 + t));
        chk("coef_load", c, 32'(coef_load), 32'(c == 2));
        chk("coef_cnt", c, 32'(coef_cnt), 32'(run));
        chk("mac_en", c, 32'(mac_en), 32'(run));
        chk("mac_clr", c, 32'(mac_clr), 32'(c == 3));
        chk("mac_last", c, 32'(mac_last), 32'(c == 3 + t));
        if (c >= 2 && c <= 4 + t)
            chk("smp_addr", c, 32'(smp_addr), 32'((wr - ((c >= 3) ? (c - 3) : 0)) & 'h3FF));
        if (c >= 2 && c <= 3 + t)
            chk("coef_ptr", c, 32'(coef_ptr), 32'(expc & 'hFFF));
        if (run)
            chk("ctr_addr", c, 32'(m_ptr + 12'(m_n)), 32'((expc + k) & 'hFFF));
    endtask

    task automatic run_pass(input int ph, input int t, input int base, input int wr,
                            input int expc, input bit hold, input bit pulse);
        @(negedge clk);
        phase     = 6'(ph);
        taps_m1   = 8'(t);
        coef_base = 12'(base);
        wr_ptr    = 10'(wr);
        start     = 1'b1;
        check_cycle(0, t, wr, expc);
        for (int c = 1; c <= 4 + t; c++) begin
            @(negedge clk);
            start     = hold ? 1'b1 : (pulse ? 1'($urandom_range(0, 1)) : 1'b0);
            phase     = 6'($urandom);
            taps_m1   = 8'($urandom);
            coef_base = 12'($urandom);
            wr_ptr    = 10'($urandom);
            check_cycle(c, t, wr, expc);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 1'b0;
            chk("idle_busy", i, 32'(busy), 0);
            chk("idle_done", i, 32'(done), 0);
        end
    endtask

    initial begin
        tbl[0] = '{phase: 0,  taps: 3,   base: 'h100, wr: 'h020, expc: 'h100, hold: 1'b0};
        tbl[1] = '{phase: 5,  taps: 15,  base: 'h010, wr: 'h100, expc: 'h060, hold: 1'b0};
        tbl[2] = '{phase: 0,  taps: 3,   base: 'h200, wr: 'h001, expc: 'h200, hold: 1'b0};
        tbl[3] = '{phase: 1,  taps: 31,  base: 'hFF0, wr: 'h3F0, expc: 'h010, hold: 1'b0};
        tbl[4] = '{phase: 2,  taps: 0,   base: 'h050, wr: 'h000, expc: 'h052, hold: 1'b0};
        tbl[5] = '{phase: 63, taps: 255, base: 'hABC, wr: 'h3FF, expc: 'h9BC, hold: 1'b1};
        tbl[6] = '{phase: 3,  taps: 2,   base: 'h7FE, wr: 'h005, expc: 'h807, hold: 1'b1};

        rst = 1'b1;
        start = 1'b0;
        phase = '0;
        taps_m1 = '0;
        coef_base = '0;
        wr_ptr = '0;
        repeat (3) @(negedge clk);
        chk_all_zero(0);
        rst = 1'b0;
        idle_cycles(2);

        // Directed table; the last two entries hold start high across back-to-back passes.
        for (int i = 0; i < 7; i++)
            run_pass(tbl[i].phase, tbl[i].taps, tbl[i].base, tbl[i].wr, tbl[i].expc,
                     tbl[i].hold, 1'b0);
        idle_cycles(3);

        // Random passes with start toggling while busy.
        for (int i = 0; i < 25; i++) begin
            int ph, t, b, w;
            ph = $urandom_range(0, 63);
            t  = $urandom_range(0, 40);
            b  = $urandom_range(0, 4095);
            w  = $urandom_range(0, 1023);
            run_pass(ph, t, b, w, (b + ph * (t + 1)) & 'hFFF, 1'b0, 1'b1);
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
        end
        idle_cycles(2);

        // Asynchronous reset during RUN: outputs clear without a clock edge, no done follows.
        @(negedge clk);
        phase = 6'd4; taps_m1 = 8'd7; coef_base = 12'h300; wr_ptr = 10'h080; start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            check_cycle(c, 7, 'h080, 'h320);
        end
        #2 rst = 1'b1;
        #1 chk_all_zero(100);
        @(negedge clk);
        chk_all_zero(101);
        rst = 1'b0;
        idle_cycles(10);

        run_pass(tbl[0].phase, tbl[0].taps, tbl[0].base, tbl[0].wr, tbl[0].expc, 1'b0, 1'b0);
        run_pass(tbl[3].phase, tbl[3].taps, tbl[3].base, tbl[3].wr, tbl[3].expc, 1'b0, 1'b0);
        idle_cycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
